seq_mul: RTL and testbench

//  Parametrised sequential shift-add multiplier; successor to the 4-bit combinational multiplier.

---
 rtl/seq_mul_pkg.sv | 5 +
 rtl/seq_mul_if.sv | 14 +
 rtl/seq_mul_mul_abs.sv | 12 +
 rtl/seq_mul.sv | 73 +++++++
 tb/tb_seq_mul.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared state encoding and default operand width for the sequential multiplier
package seq_mul_pkg;
  localparam int DEF_WIDTH = 4;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/seq_mul_if.sv
// seq_mul_if: operand/product valid-ready bundle between a producer and the multiplier
interface seq_mul_if #(parameter int WIDTH = seq_mul_pkg::DEF_WIDTH);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               in_signed;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_p;
  logic               busy;
  modport master (output in_valid, in_a, in_b, in_signed, out_ready, input in_ready, out_valid, out_p, busy);
  modport slave  (input in_valid, in_a, in_b, in_signed, out_ready, output in_ready, out_valid, out_p, busy);
endinterface

// File: rtl/seq_mul_mul_abs.sv
// mul_abs: splits an operand into unsigned magnitude and sign; -2^(W-1) maps to 2^(W-1)
module mul_abs #(parameter int WIDTH = 4) (
  input  logic [WIDTH-1:0] x,
  input  logic             is_signed,
  output logic [WIDTH-1:0] mag,
  output logic             sign
);
  always_comb begin
    sign = is_signed & x[WIDTH-1];
    mag  = sign ? -x : x;
  end
endmodule

// File: rtl/seq_mul.sv
// seq_mul: shift-add multiplier on magnitudes, one operation in flight, sign applied on exit
module seq_mul
  import seq_mul_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter bit EARLY_EXIT = 1'b0
) (
  input logic     clk,
  input logic     rst,
  seq_mul_if.slave bus
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  state_t            state;
  logic [W2-1:0]     mcand, acc, acc_n;
  logic [WIDTH-1:0]  mplier, mag_a, mag_b;
  logic [CW-1:0]     cnt, cnt_n;
  logic              neg, sa, sb, accept, last;
  mul_abs #(.WIDTH(WIDTH)) u_abs_a (.x(bus.in_a), .is_signed(bus.in_signed), .mag(mag_a), .sign(sa));
  mul_abs #(.WIDTH(WIDTH)) u_abs_b (.x(bus.in_b), .is_signed(bus.in_signed), .mag(mag_b), .sign(sb));
  // early exit looks at the multiplier as it will be after this cycle's shift
  always_comb begin
    accept = bus.in_valid & bus.in_ready;
    acc_n  = mplier[0] ? acc + mcand : acc;
    cnt_n  = cnt + 1'b1;
    last   = (cnt_n == CW'(WIDTH)) || (EARLY_EXIT && mplier[WIDTH-1:1] == '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      mcand         <= '0;
      acc           <= '0;
      mplier        <= '0;
      cnt           <= '0;
      neg           <= 1'b0;
      bus.out_p     <= '0;
      bus.out_valid <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          mcand        <= {{WIDTH{1'b0}}, mag_a};
          mplier       <= mag_b;
          acc          <= '0;
          cnt          <= '0;
          neg          <= sa ^ sb;
          bus.in_ready <= 1'b0;
          bus.busy     <= 1'b1;
          state        <= CALC;
        end
        CALC: begin
          acc    <= acc_n;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt_n;
          if (last) begin
            bus.out_p     <= neg ? -acc_n : acc_n;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.busy      <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mul.sv
// tb_seq_mul: three multiplier configurations (W4, W4 early-exit, W8) against table and random ops
module tb_seq_mul;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  seq_mul_if #(.WIDTH(4)) u0 ();
  seq_mul_if #(.WIDTH(4)) u1 ();
  seq_mul_if #(.WIDTH(8)) u2 ();
  seq_mul #(.WIDTH(4), .EARLY_EXIT(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(u0));
  seq_mul #(.WIDTH(4), .EARLY_EXIT(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(u1));
  seq_mul #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut2 (.clk(clk), .rst(rst), .bus(u2));

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] sb_q[$];

  typedef struct {
    int         d;
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [15:0] p;
    int         cyc;
    int         hold;
    string      nm;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int wid(input int d);
    return d == 2 ? 8 : 4;
  endfunction

  function automatic logic rdy(input int d);
    return d == 0 ? u0.in_ready : d == 1 ? u1.in_ready : u2.in_ready;
  endfunction
  function automatic logic ov(input int d);
    return d == 0 ? u0.out_valid : d == 1 ? u1.out_valid : u2.out_valid;
  endfunction
  function automatic logic bsy(input int d);
    return d == 0 ? u0.busy : d == 1 ? u1.busy : u2.busy;
  endfunction
  function automatic logic [15:0] op(input int d);
    return d == 0 ? {8'h00, u0.out_p} : d == 1 ? {8'h00, u1.out_p} : u2.out_p;
  endfunction

  task automatic set_in(input int d, input logic v, input logic [7:0] a, input logic [7:0] b, input logic s);
    case (d)
      0: begin u0.in_valid = v; u0.in_a = a[3:0]; u0.in_b = b[3:0]; u0.in_signed = s; end
      1: begin u1.in_valid = v; u1.in_a = a[3:0]; u1.in_b = b[3:0]; u1.in_signed = s; end
      default: begin u2.in_valid = v; u2.in_a = a; u2.in_b = b; u2.in_signed = s; end
    endcase
  endtask

  task automatic set_ordy(input int d, input logic r);
    case (d)
      0: u0.out_ready = r;
      1: u1.out_ready = r;
      default: u2.out_ready = r;
    endcase
  endtask

  function automatic int sval(input int w, input logic [7:0] x, input logic s);
    int v;
    v = int'(x) & ((1 << w) - 1);
    if (s && x[w-1]) v -= (1 << w);
    return v;
  endfunction

  function automatic logic [15:0] model(input int w, input logic [7:0] a, input logic [7:0] b, input logic s);
    int r;
    r = sval(w, a, s) * sval(w, b, s);
    return 16'(r & ((1 << (2 * w)) - 1));
  endfunction

  function automatic int model_cyc(input int d, input logic [7:0] b, input logic s);
    int w, mb, c;
    w = wid(d);
    if (d != 1) return w;
    mb = sval(w, b, s);
    if (mb < 0) mb = -mb;
    c = 1;
    while (((mb >> c) != 0) && c < w) c++;
    return c;
  endfunction

  task automatic do_op(input int d, input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [15:0] exp, input int cyc, input int hold, input string nm);
    int n;
    logic [15:0] p0, e;
    n = 0;
    while (!rdy(d) && n < 20) begin tick(); n++; end
    check({nm, " in_ready"}, 16'(rdy(d)), 16'd1);
    sb_q.push_back(exp);
    set_in(d, 1'b1, a, b, s);
    tick();
    set_in(d, 1'b0, 8'hxx, 8'hxx, 1'bx);
    check({nm, " busy"}, 16'(bsy(d)), 16'd1);
    n = 1;
    while (!ov(d) && n < 40) begin tick(); n++; end
    check({nm, " latency"}, 16'(n), 16'(cyc + 1));
    p0 = op(d);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({nm, " hold valid"}, 16'(ov(d)), 16'd1);
      check({nm, " hold in_ready"}, 16'(rdy(d)), 16'd0);
      check({nm, " hold p"}, op(d), p0);
    end
    e = sb_q.pop_front();
    check(nm, op(d), e);
    set_ordy(d, 1'b1);
    tick();
    set_ordy(d, 1'b0);
    check({nm, " drop valid"}, 16'(ov(d)), 16'd0);
    check({nm, " keep p"}, op(d), e);
    check({nm, " back idle"}, 16'(rdy(d)), 16'd1);
  endtask

  vec_t tbl[$];

  initial begin
    for (int d = 0; d < 3; d++) begin
      set_in(d, 1'b0, 8'h00, 8'h00, 1'b0);
      set_ordy(d, 1'b0);
    end
    tbl.push_back('{0, 8'h07, 8'h06, 1'b0, 16'h002A, 4, 0, "u 7x6"});
    tbl.push_back('{0, 8'h0F, 8'h0F, 1'b0, 16'h00E1, 4, 0, "u 15x15"});
    tbl.push_back('{0, 8'h08, 8'h07, 1'b1, 16'h00C8, 4, 0, "s -8x7"});
    tbl.push_back('{0, 8'h08, 8'h08, 1'b1, 16'h0040, 4, 0, "s -8x-8"});
    tbl.push_back('{0, 8'h0F, 8'h0F, 1'b1, 16'h0001, 4, 0, "s -1x-1"});
    tbl.push_back('{1, 8'h09, 8'h00, 1'b0, 16'h0000, 1, 0, "ee 9x0"});
    tbl.push_back('{1, 8'h05, 8'h02, 1'b0, 16'h000A, 2, 0, "ee 5x2"});
    tbl.push_back('{0, 8'h0B, 8'h0D, 1'b0, 16'h008F, 4, 3, "bp 11x13"});
    tbl.push_back('{2, 8'h80, 8'h80, 1'b1, 16'h4000, 8, 0, "w8 -128x-128"});
    tbl.push_back('{2, 8'h7F, 8'hFF, 1'b1, 16'hFF81, 8, 0, "w8 127x-1"});
    repeat (3) tick();
    rst = 1'b0;
    tick();
    for (int d = 0; d < 3; d++) begin
      check("reset valid", 16'(ov(d)), 16'd0);
      check("reset p", op(d), 16'd0);
      check("reset in_ready", 16'(rdy(d)), 16'd1);
      check("reset busy", 16'(bsy(d)), 16'd0);
    end
    foreach (tbl[i])
      do_op(tbl[i].d, tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].p, tbl[i].cyc, tbl[i].hold, tbl[i].nm);
    set_in(0, 1'b1, 8'h07, 8'h07, 1'b0);
    tick();
    set_in(0, 1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort valid", 16'(ov(0)), 16'd0);
    check("abort p", op(0), 16'd0);
    check("abort in_ready", 16'(rdy(0)), 16'd1);
    check("abort busy", 16'(bsy(0)), 16'd0);
    do_op(0, 8'h03, 8'h03, 1'b0, 16'h0009, 4, 0, "post-abort 3x3");
    for (int k = 0; k < 1200; k++) begin
      int d;
      logic [7:0] a, b;
      logic s;
      d = k < 100 ? 0 : k < 200 ? 1 : 2;
      a = 8'($urandom);
      b = 8'($urandom);
      if (d == 1 && k % 3 == 0) b = b & 8'h03;
      s = 1'($urandom);
      do_op(d, a, b, s, model(wid(d), a, b, s), model_cyc(d, b, s), k % 50 == 7 ? 2 : 0, "rand");
    end
    check("scoreboard empty", 16'(sb_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
